// File: rtl/cpu_run_monitor_pkg.sv
// Shared encodings for the CPU run monitor: controller states, halt causes,
// and an index-width helper that never returns zero.
package cpu_run_monitor_pkg;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_DUMP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] CAUSE_NONE        = 2'd0;
  localparam logic [1:0] CAUSE_HALT_PC     = 2'd1;
  localparam logic [1:0] CAUSE_SELF_LOOP   = 2'd2;
  localparam logic [1:0] CAUSE_CYCLE_LIMIT = 2'd3;

  // Index width for an n-entry space; a single entry still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_run_monitor_trace_ring.sv
// Ring trace of the most recent retired {pc, inst} pairs with a held-entry
// count and a combinational read indexed relative to the oldest held entry.
module cpu_run_monitor_trace_ring
  import cpu_run_monitor_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [PC_W-1:0]           wr_pc,
  input  logic [INST_W-1:0]         wr_inst,
  input  logic [idx_w(DEPTH)-1:0]   rd_idx,
  output logic [PC_W-1:0]           rd_pc,
  output logic [INST_W-1:0]         rd_inst,
  output logic                      rd_valid
);

  localparam int AW = idx_w(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       held;
  logic [AW-1:0]     oldest;
  logic [AW-1:0]     rd_addr;
  logic [PC_W-1:0]   ram_pc   [DEPTH];
  logic [INST_W-1:0] ram_inst [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      held   <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (held != (AW+1)'(DEPTH)) held <= held + 1'b1;
    end
  end

  // NOTE: storage has no reset; the held count masks stale entries, so
  // clearing the RAM would only cost a reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_pc[wr_ptr]   <= wr_pc;
      ram_inst[wr_ptr] <= wr_inst;
    end
  end

  assign oldest   = (held == (AW+1)'(DEPTH)) ? wr_ptr : '0;
  assign rd_addr  = oldest + rd_idx;
  assign rd_pc    = ram_pc[rd_addr];
  assign rd_inst  = ram_inst[rd_addr];
  assign rd_valid = ({1'b0, rd_idx} < held);

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller beside a CPU: counts cycles/retires, traces retires, detects
// halt conditions, freezes the CPU and then streams out DUMP_N register words.
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter int              INST_W      = 32,
  parameter int              TRACE_DEPTH = 16,
  parameter int              CNT_W       = 16,
  parameter int              CYCLE_LIMIT = 40,
  parameter logic [PC_W-1:0] HALT_PC     = '1,
  parameter int              LOOP_N      = 4,
  parameter int              DUMP_N      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            run_en,
  input  logic                            retire,
  input  logic [PC_W-1:0]                 pc_i,
  input  logic [INST_W-1:0]               inst_i,
  output logic                            cpu_stall,
  output logic [CNT_W-1:0]                cycle_cnt,
  output logic [CNT_W-1:0]                instr_cnt,
  output logic [1:0]                      halt_cause,
  input  logic [idx_w(TRACE_DEPTH)-1:0]   tr_idx,
  output logic [PC_W-1:0]                 tr_pc,
  output logic [INST_W-1:0]               tr_inst,
  output logic                            tr_valid,
  output logic [idx_w(DUMP_N)-1:0]        dump_addr,
  input  logic [31:0]                     dump_data,
  output logic                            dump_valid,
  output logic [idx_w(DUMP_N)-1:0]        dump_idx,
  output logic [31:0]                     dump_word,
  output logic                            done
);

  localparam int              DA_W    = idx_w(DUMP_N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] loop_cnt;
  logic [PC_W-1:0]  last_pc;

  logic             advance;
  logic             rec;
  logic [CNT_W-1:0] cycle_nxt;
  logic [CNT_W-1:0] instr_nxt;
  logic [CNT_W-1:0] loop_nxt;
  logic             hit_pc;
  logic             hit_loop;
  logic             hit_cyc;
  logic [1:0]       cause_nxt;

  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    advance   = (state == ST_RUN) && run_en;
    rec       = advance && retire;
    cycle_nxt = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + 1'b1;
    instr_nxt = (instr_cnt == CNT_MAX) ? instr_cnt : instr_cnt + 1'b1;
    loop_nxt  = CNT_W'(1);
    if (loop_cnt != '0 && pc_i == last_pc)
      loop_nxt = (loop_cnt == CNT_MAX) ? loop_cnt : loop_cnt + 1'b1;

    // Checks see the counts as they will be after this edge.
    hit_pc   = retire && (HALT_PC != '1) && (pc_i == HALT_PC);
    hit_loop = retire && (LOOP_N != 0) && (loop_nxt == CNT_W'(LOOP_N));
    hit_cyc  = (CYCLE_LIMIT != 0) && (cycle_nxt == CNT_W'(CYCLE_LIMIT));

    cause_nxt = CAUSE_NONE;
    if (hit_pc)        cause_nxt = CAUSE_HALT_PC;
    else if (hit_loop) cause_nxt = CAUSE_SELF_LOOP;
    else if (hit_cyc)  cause_nxt = CAUSE_CYCLE_LIMIT;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_RUN;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      loop_cnt   <= '0;
      last_pc    <= '0;
      halt_cause <= CAUSE_NONE;
      cpu_stall  <= 1'b0;
      dump_addr  <= '0;
      dump_idx   <= '0;
      dump_word  <= '0;
      dump_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (advance) begin
            cycle_cnt <= cycle_nxt;
            if (retire) begin
              instr_cnt <= instr_nxt;
              loop_cnt  <= loop_nxt;
              last_pc   <= pc_i;
            end
            if (cause_nxt != CAUSE_NONE) begin
              halt_cause <= cause_nxt;
              cpu_stall  <= 1'b1;
              state      <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          dump_addr <= '0;
          state     <= ST_DUMP;
        end
        ST_DUMP: begin
          dump_word  <= dump_data;
          dump_idx   <= dump_addr;
          dump_valid <= 1'b1;
          if (dump_addr == DA_W'(DUMP_N - 1)) state     <= ST_DONE;
          else                                dump_addr <= dump_addr + 1'b1;
        end
        default: begin
          dump_valid <= 1'b0;
          done       <= 1'b1;
        end
      endcase
    end
  end

  cpu_run_monitor_trace_ring #(
    .DEPTH  (TRACE_DEPTH),
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_trace (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (rec),
    .wr_pc    (pc_i),
    .wr_inst  (inst_i),
    .rd_idx   (tr_idx),
    .rd_pc    (tr_pc),
    .rd_inst  (tr_inst),
    .rd_valid (tr_valid)
  );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: two instances differing only in HALT_PC,
// with a queue of expected dump words and trace entries.
module tb_cpu_run_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_en;
  logic        retire;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [3:0]  tr_idx;

  logic        cpu_stall_a, tr_valid_a, dump_valid_a, done_a;
  logic [15:0] cycle_cnt_a, instr_cnt_a;
  logic [1:0]  halt_cause_a;
  logic [31:0] tr_pc_a, tr_inst_a, dump_data_a, dump_word_a;
  logic [4:0]  dump_addr_a, dump_idx_a;

  logic        cpu_stall_b, tr_valid_b, dump_valid_b, done_b;
  logic [15:0] cycle_cnt_b, instr_cnt_b;
  logic [1:0]  halt_cause_b;
  logic [31:0] tr_pc_b, tr_inst_b, dump_data_b, dump_word_b;
  logic [4:0]  dump_addr_b, dump_idx_b;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Register file model: rf[k] = k*3, read combinationally.
  assign dump_data_a = {27'd0, dump_addr_a} * 32'd3;
  assign dump_data_b = {27'd0, dump_addr_b} * 32'd3;

  cpu_run_monitor #(.HALT_PC(32'h0000_0008)) dut_a (
    .clk(clk), .rst(rst), .run_en(run_en), .retire(retire), .pc_i(pc_i), .inst_i(inst_i),
    .cpu_stall(cpu_stall_a), .cycle_cnt(cycle_cnt_a), .instr_cnt(instr_cnt_a),
    .halt_cause(halt_cause_a), .tr_idx(tr_idx), .tr_pc(tr_pc_a), .tr_inst(tr_inst_a),
    .tr_valid(tr_valid_a), .dump_addr(dump_addr_a), .dump_data(dump_data_a),
    .dump_valid(dump_valid_a), .dump_idx(dump_idx_a), .dump_word(dump_word_a), .done(done_a)
  );

  cpu_run_monitor #(.HALT_PC(32'h0000_1000)) dut_b (
    .clk(clk), .rst(rst), .run_en(run_en), .retire(retire), .pc_i(pc_i), .inst_i(inst_i),
    .cpu_stall(cpu_stall_b), .cycle_cnt(cycle_cnt_b), .instr_cnt(instr_cnt_b),
    .halt_cause(halt_cause_b), .tr_idx(tr_idx), .tr_pc(tr_pc_b), .tr_inst(tr_inst_b),
    .tr_valid(tr_valid_b), .dump_addr(dump_addr_b), .dump_data(dump_data_b),
    .dump_valid(dump_valid_b), .dump_idx(dump_idx_b), .dump_word(dump_word_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic ret, input logic [31:0] pc,
                       input logic [31:0] inst);
    run_en = en;
    retire = ret;
    pc_i   = pc;
    inst_i = inst;
  endtask

  task automatic do_reset(input string tag);
    rst    = 1'b0;
    tr_idx = 4'd0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check({tag, "_rst_cycle"}, cycle_cnt_b, 0);
    check({tag, "_rst_instr"}, instr_cnt_b, 0);
    check({tag, "_rst_cause"}, halt_cause_b, 0);
    check({tag, "_rst_stall"}, cpu_stall_b, 0);
    check({tag, "_rst_done"}, done_b, 0);
    check({tag, "_rst_dvalid"}, dump_valid_b, 0);
    check({tag, "_rst_trvalid"}, tr_valid_b, 0);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          pulses;
    int          gaps;
    bit          seen_done;
    bit          prev_valid;
    logic [4:0]  last_idx;
    logic [31:0] exp_w;

    // Test 1: cycle limit with no retires.
    do_reset("t1");
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    repeat (39) tick();
    check("t1_cycle39", cycle_cnt_b, 39);
    check("t1_stall_before", cpu_stall_b, 0);
    tick();
    check("t1_cause", halt_cause_b, 3);
    check("t1_cycle", cycle_cnt_b, 40);
    check("t1_instr", instr_cnt_b, 0);
    check("t1_stall", cpu_stall_b, 1);
    repeat (5) tick();
    check("t1_cycle_frozen", cycle_cnt_b, 40);

    // Test 2: halt-PC hit at 0x8 on dut_a.
    do_reset("t2");
    drive(1'b1, 1'b1, 32'h0, 32'h2000_0000); tick();
    drive(1'b1, 1'b1, 32'h4, 32'h2000_0001); tick();
    check("t2_cause_early", halt_cause_a, 0);
    drive(1'b1, 1'b1, 32'h8, 32'h2000_0002); tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("t2_cause", halt_cause_a, 1);
    check("t2_instr", instr_cnt_a, 3);
    check("t2_stall", cpu_stall_a, 1);
    tr_idx = 4'd2; #1;
    check("t2_tr2_pc", tr_pc_a, 32'h8);
    check("t2_tr2_inst", tr_inst_a, 32'h2000_0002);
    check("t2_tr2_valid", tr_valid_a, 1);
    tr_idx = 4'd3; #1;
    check("t2_tr3_valid", tr_valid_a, 0);

    // Test 3: branch-to-self loop.
    do_reset("t3");
    drive(1'b1, 1'b1, 32'h0000_000C, 32'h1000_FFFF);
    repeat (3) tick();
    check("t3_cause_early", halt_cause_b, 0);
    check("t3_stall_early", cpu_stall_b, 0);
    tick();
    check("t3_cause", halt_cause_b, 2);
    check("t3_instr", instr_cnt_b, 4);

    // Test 4: ring wrap after 20 retires, then run_en=0 must freeze everything.
    do_reset("t4");
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 32'(4 * k), 32'h3000_0000 | 32'(k));
      tick();
    end
    drive(1'b0, 1'b1, 32'h200, 32'h0);
    repeat (3) tick();
    check("t4_instr", instr_cnt_b, 20);
    check("t4_cycle", cycle_cnt_b, 20);
    check("t4_cause", halt_cause_b, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(4 * (i + 4)));
    for (int i = 0; i < 16; i++) begin
      tr_idx = 4'(i); #1;
      exp_w = exp_q.pop_front();
      check($sformatf("t4_tr%0d_pc", i), tr_pc_b, exp_w);
      check($sformatf("t4_tr%0d_inst", i), tr_inst_b, 32'h3000_0000 | 32'(i + 4));
      check($sformatf("t4_tr%0d_valid", i), tr_valid_b, 1);
    end

    // Test 5a: halt-PC retire on cycle 40 beats cycle limit, then full dump.
    do_reset("t5a");
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    repeat (39) tick();
    drive(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_0000);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("t5a_cause", halt_cause_b, 1);
    check("t5a_cycle", cycle_cnt_b, 40);
    check("t5a_instr", instr_cnt_b, 1);
    for (int k = 0; k < 32; k++) exp_q.push_back(32'(k * 3));
    pulses = 0; gaps = 0; seen_done = 0; prev_valid = 0; last_idx = '0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      tick();
      if (done_b) begin
        seen_done = 1;
        check("t5a_done_after_last", {prev_valid, last_idx}, {1'b1, 5'd31});
        check("t5a_done_dvalid", dump_valid_b, 0);
      end else if (dump_valid_b) begin
        if (exp_q.size() > 0) exp_w = exp_q.pop_front();
        else                  exp_w = 32'hBAD0_BAD0;
        check($sformatf("t5a_idx%0d", pulses), dump_idx_b, pulses);
        check($sformatf("t5a_word%0d", pulses), dump_word_b, exp_w);
        pulses++;
        last_idx   = dump_idx_b;
        prev_valid = 1;
      end else begin
        if (pulses > 0) gaps++;
        prev_valid = 0;
      end
    end
    if (!seen_done) check("t5a_done_timeout", done_b, 1);
    check("t5a_pulses", pulses, 32);
    check("t5a_gaps", gaps, 0);
    check("t5a_queue_left", exp_q.size(), 0);
    repeat (3) tick();
    check("t5a_done_held", done_b, 1);
    check("t5a_dvalid_held", dump_valid_b, 0);
    exp_q.delete();

    // Test 5b: 4th same-PC retire on cycle 40 beats cycle limit.
    do_reset("t5b");
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    repeat (36) tick();
    drive(1'b1, 1'b1, 32'h0000_000C, 32'h1000_FFFF);
    repeat (4) tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("t5b_cause", halt_cause_b, 2);
    check("t5b_cycle", cycle_cnt_b, 40);
    check("t5b_instr", instr_cnt_b, 4);

    // Test 6: reset on the 5th dump pulse, then half-rate run_en.
    do_reset("t6");
    drive(1'b1, 1'b1, 32'h40, 32'h1); tick();
    drive(1'b1, 1'b1, 32'h44, 32'h2); tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    repeat (38) tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("t6_cause", halt_cause_b, 3);
    check("t6_trvalid_before", tr_valid_b, 1);
    pulses = 0;
    for (int c = 0; c < 60 && pulses < 5; c++) begin
      tick();
      if (dump_valid_b) pulses++;
    end
    check("t6_fifth_pulse_idx", {dump_valid_b, dump_idx_b}, {1'b1, 5'd4});
    rst = 1'b0;
    tick();
    check("t6_stall", cpu_stall_b, 0);
    check("t6_cycle", cycle_cnt_b, 0);
    check("t6_instr", instr_cnt_b, 0);
    check("t6_done", done_b, 0);
    check("t6_dvalid", dump_valid_b, 0);
    check("t6_cause_clr", halt_cause_b, 0);
    check("t6_trvalid", tr_valid_b, 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive((i % 2) == 0, 1'b0, 32'h0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("t6_half_rate", cycle_cnt_b, 10);
    check("t6_no_halt", cpu_stall_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
